// File: rtl/shared_resource_queue_pkg.sv
// Shared types and default configuration for the shared resource request queue.
// The engine state encoding is fixed: IDLE=0, PROCESS=1, HOLD=2.
package shared_resource_queue_pkg;

  localparam int unsigned AddressWidth      = 5;
  localparam int unsigned DataWidth         = 32;
  localparam int unsigned IdWidth           = 4;
  localparam int unsigned ResourceDelay     = 3;
  localparam int unsigned ResourceFifoDepth = 4;
  localparam int unsigned ResourceOffset    = 512;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StProcess = 2'd1,
    StHold    = 2'd2
  } engine_state_e;

endpackage

// File: rtl/shared_resource_queue_request_fifo.sv
// Synchronous request FIFO with wrap-around pointers; the extra pointer bit
// distinguishes full from empty. A push while full is dropped.
module shared_resource_queue_request_fifo #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [Width-1:0]           wdata_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth+1)-1:0] occupancy_o
);

  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned PtrW = IdxW + 1;
  localparam int unsigned OccW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign full_o      = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                       (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign rdata_o     = mem_q[rd_ptr_q[IdxW-1:0]];
  assign occupancy_o = OccW'(wr_ptr_q - rd_ptr_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[IdxW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/shared_resource_queue.sv
// Queued shared resource: FIFO-buffered requests serviced one at a time with a
// fixed processing delay, results held in an output register under backpressure.
module shared_resource_queue
  import shared_resource_queue_pkg::*;
#(
  parameter int unsigned ADDR_W = AddressWidth,
  parameter int unsigned DATA_W = DataWidth,
  parameter int unsigned ID_W   = IdWidth,
  parameter int unsigned DELAY  = ResourceDelay,
  parameter int unsigned DEPTH  = ResourceFifoDepth,
  parameter int unsigned OFFSET = ResourceOffset
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [ADDR_W-1:0]          in_address_i,
  input  logic [ID_W-1:0]            in_id_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_W-1:0]          out_data_o,
  output logic [ID_W-1:0]            out_id_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic                       busy_o
);

  localparam int unsigned EntryW = ADDR_W + ID_W;
  localparam int unsigned CntW   = $clog2(DELAY + 1);

  engine_state_e     state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]   out_id_q, out_id_d;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_wdata, fifo_rdata;

  assign fifo_wdata = {in_address_i, in_id_i};

  shared_resource_queue_request_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_request_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (in_valid_i),
    .pop_i       (fifo_pop),
    .wdata_i     (fifo_wdata),
    .rdata_o     (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .occupancy_o (occupancy_o)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    id_d        = id_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop         = 1'b1;
          {addr_d, id_d}   = fifo_rdata;
          cnt_d            = '0;
          state_d          = StProcess;
        end
      end
      StProcess: begin
        if (cnt_q == CntW'(DELAY - 1)) begin
          out_valid_d = 1'b1;
          out_data_d  = DATA_W'(addr_q) + DATA_W'(OFFSET);
          out_id_d    = id_q;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (out_valid_q && out_ready_i) begin
          out_valid_d = 1'b0;
          // Chain straight into the next request to sustain one result per DELAY+1 cycles.
          if (!fifo_empty) begin
            fifo_pop       = 1'b1;
            {addr_d, id_d} = fifo_rdata;
            cnt_d          = '0;
            state_d        = StProcess;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign in_ready_o  = !fifo_full;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_shared_resource_queue.sv
// Directed bench for shared_resource_queue: a default instance (DELAY=3, DEPTH=4,
// OFFSET=512) and a narrow instance (DATA_W=10, OFFSET=1000) for result wrap-around.
module tb_shared_resource_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [4:0]  in_address = '0;
  logic [3:0]  in_id = '0, out_id;
  logic [31:0] out_data;
  logic [2:0]  occupancy;

  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, busy2;
  logic [4:0]  in_address2 = '0;
  logic [3:0]  in_id2 = '0, out_id2;
  logic [9:0]  out_data2;
  logic [2:0]  occupancy2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  shared_resource_queue #(
    .ADDR_W (5), .DATA_W (32), .ID_W (4), .DELAY (3), .DEPTH (4), .OFFSET (512)
  ) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_address_i (in_address),
    .in_id_i      (in_id),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_id_o     (out_id),
    .occupancy_o  (occupancy),
    .busy_o       (busy)
  );

  shared_resource_queue #(
    .ADDR_W (5), .DATA_W (10), .ID_W (4), .DELAY (3), .DEPTH (4), .OFFSET (1000)
  ) u_dut_narrow (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid2),
    .in_ready_o   (in_ready2),
    .in_address_i (in_address2),
    .in_id_i      (in_id2),
    .out_valid_o  (out_valid2),
    .out_ready_i  (out_ready2),
    .out_data_o   (out_data2),
    .out_id_o     (out_id2),
    .occupancy_o  (occupancy2),
    .busy_o       (busy2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid   = 1'b1;
    in_address = 5'd3;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0d exp 0", out_valid); else passed++;
    total++; if (out_data !== 32'd0) $display("FAIL rst_data: got %0d exp 0", out_data); else passed++;
    total++; if (out_id !== 4'd0) $display("FAIL rst_id: got %0d exp 0", out_id); else passed++;
    total++; if (occupancy !== 3'd0) $display("FAIL rst_occ: got %0d exp 0", occupancy); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0d exp 0", busy); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0d exp 1", in_ready); else passed++;
    total++; if (out_valid2 !== 1'b0) $display("FAIL rst_valid2: got %0d exp 0", out_valid2); else passed++;
    in_valid = 1'b0;
    #2 rst = 1'b0;
    tick();
    total++; if (occupancy !== 3'd0) $display("FAIL rst_push_ignored: occ got %0d exp 0", occupancy); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_release_busy: got %0d exp 0", busy); else passed++;
  endtask

  task automatic test_single();
    out_ready  = 1'b1;
    in_address = 5'd5;
    in_id      = 4'd2;
    in_valid   = 1'b1;
    tick();  // E0
    in_valid = 1'b0;
    total++; if (occupancy !== 3'd1) $display("FAIL single_occ: got %0d exp 1", occupancy); else passed++;
    for (int c = 1; c <= 5; c++) begin
      tick();
      total++;
      if (out_valid !== (c == 4)) $display("FAIL single_valid_e%0d: got %0d exp %0d", c, out_valid, (c == 4));
      else passed++;
      if (c == 1) begin
        total++; if (busy !== 1'b1) $display("FAIL single_busy: got %0d exp 1", busy); else passed++;
        total++; if (occupancy !== 3'd0) $display("FAIL single_pop_occ: got %0d exp 0", occupancy); else passed++;
      end
      if (c == 4) begin
        total++; if (out_data !== 32'd517) $display("FAIL single_data: got %0d exp 517", out_data); else passed++;
        total++; if (out_id !== 4'd2) $display("FAIL single_id: got %0d exp 2", out_id); else passed++;
      end
      if (c == 5) begin
        total++; if (busy !== 1'b0) $display("FAIL single_busy_fall: got %0d exp 0", busy); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      in_valid   = (c < 4);
      in_address = 5'(c);
      in_id      = 4'(c);
      tick();  // edge Ec
      if (out_valid === 1'b1) begin
        total++;
        if (c != 4 + 4 * n) $display("FAIL b2b_timing_%0d: got edge %0d exp %0d", n, c, 4 + 4 * n);
        else passed++;
        total++;
        if (out_data !== 32'(512 + n)) $display("FAIL b2b_data_%0d: got %0d exp %0d", n, out_data, 512 + n);
        else passed++;
        total++;
        if (out_id !== 4'(n)) $display("FAIL b2b_id_%0d: got %0d exp %0d", n, out_id, n);
        else passed++;
        n++;
      end
    end
    in_valid = 1'b0;
    total++; if (n != 4) $display("FAIL b2b_count: got %0d exp 4", n); else passed++;
  endtask

  task automatic test_backpressure();
    int n = 1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid   = 1'b1;
      in_address = 5'(8 + k);
      in_id      = 4'(4 + k);
      tick();
    end
    in_valid = 1'b0;
    total++; if (occupancy !== 3'd4) $display("FAIL bp_occ_full: got %0d exp 4", occupancy); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0d exp 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %0d exp 1", out_valid); else passed++;
    total++; if (out_data !== 32'd520) $display("FAIL bp_hold_data: got %0d exp 520", out_data); else passed++;
    // Sixth request must bounce off the full FIFO.
    in_valid   = 1'b1;
    in_address = 5'd13;
    in_id      = 4'd9;
    tick();
    tick();
    in_valid = 1'b0;
    total++; if (occupancy !== 3'd4) $display("FAIL bp_sixth_rejected: occ got %0d exp 4", occupancy); else passed++;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'd520 || out_id !== 4'd4)
        $display("FAIL bp_stable_%0d: got v=%0d d=%0d id=%0d exp v=1 d=520 id=4", c, out_valid, out_data, out_id);
      else passed++;
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %0d exp 0", out_valid); else passed++;
    total++; if (occupancy !== 3'd3) $display("FAIL bp_release_occ: got %0d exp 3", occupancy); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %0d exp 1", in_ready); else passed++;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (out_valid === 1'b1) begin
        total++;
        if (out_data !== 32'(520 + n) || out_id !== 4'(4 + n))
          $display("FAIL bp_drain_%0d: got d=%0d id=%0d exp d=%0d id=%0d", n, out_data, out_id, 520 + n, 4 + n);
        else passed++;
        n++;
      end
    end
    total++; if (n != 5) $display("FAIL bp_drain_count: got %0d exp 5", n); else passed++;
    total++; if (occupancy !== 3'd0) $display("FAIL bp_final_occ: got %0d exp 0", occupancy); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL bp_final_busy: got %0d exp 0", busy); else passed++;
  endtask

  task automatic test_wrap();
    bit seen = 1'b0;
    out_ready2  = 1'b1;
    in_valid2   = 1'b1;
    in_address2 = 5'd31;
    in_id2      = 4'd5;
    tick();
    in_valid2 = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (out_valid2 === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) $display("FAIL wrap_timeout: got no result exp out_valid within 10 cycles"); else passed++;
    total++; if (out_data2 !== 10'd7) $display("FAIL wrap_data: got %0d exp 7", out_data2); else passed++;
    total++; if (out_id2 !== 4'd5) $display("FAIL wrap_id: got %0d exp 5", out_id2); else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid   = 1'b1;
      in_address = 5'(1 + k);
      in_id      = 4'(k);
      tick();
    end
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL mid_pre_busy: got %0d exp 1", busy); else passed++;
    total++; if (occupancy !== 3'd2) $display("FAIL mid_pre_occ: got %0d exp 2", occupancy); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0d exp 0", out_valid); else passed++;
    total++; if (out_data !== 32'd0) $display("FAIL mid_rst_data: got %0d exp 0", out_data); else passed++;
    total++; if (out_id !== 4'd0) $display("FAIL mid_rst_id: got %0d exp 0", out_id); else passed++;
    total++; if (occupancy !== 3'd0) $display("FAIL mid_rst_occ: got %0d exp 0", occupancy); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %0d exp 0", busy); else passed++;
    #2 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || occupancy !== 3'd0)
        $display("FAIL mid_post_quiet_%0d: got v=%0d occ=%0d exp v=0 occ=0", c, out_valid, occupancy);
      else passed++;
    end
    in_valid   = 1'b1;
    in_address = 5'd7;
    in_id      = 4'd3;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++; if (!seen) $display("FAIL mid_new_timeout: got no result exp out_valid within 10 cycles"); else passed++;
    total++; if (out_data !== 32'd519) $display("FAIL mid_new_data: got %0d exp 519", out_data); else passed++;
    total++; if (out_id !== 4'd3) $display("FAIL mid_new_id: got %0d exp 3", out_id); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
